// File: rtl/axi_lite_intc_gpio_slave.sv
// AXI4-Lite slave with a small level-interrupt controller, an LED register and a scratch word.
// Optional macro AXI_INTC_SW_IRQ_EN makes ISR writable (software-raised interrupts).
module axi_lite_intc_gpio_slave #(
    parameter int NUM_IRQ   = 4,
    parameter int LED_WIDTH = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [5:0]           s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [5:0]           s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    input  logic [NUM_IRQ-1:0]   irq_in,
    output logic                 irq,
    output logic [LED_WIDTH-1:0] leds
);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] LAST_REG    = 4'd5;

    logic [0:0]           w_state_q, w_state_d;
    logic [0:0]           r_state_q, r_state_d;
    logic                 awready_q, awready_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q, rvalid_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [NUM_IRQ-1:0]   isr_q, isr_d;
    logic [NUM_IRQ-1:0]   ier_q, ier_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          scratch_q, scratch_d;
    logic                 irq_q, irq_d;

    logic                 wr_en;
    logic [3:0]           wr_idx, rd_idx;
    logic [NUM_IRQ-1:0]   iar_clr, sw_set;
    logic [31:0]          rd_word;
    logic [3:0]           unused_addr_bits;

    assign unused_addr_bits = {s_axi_awaddr[1:0], s_axi_araddr[1:0]};
    assign wr_idx = s_axi_awaddr[5:2];
    assign rd_idx = s_axi_araddr[5:2];

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            4'd0:    rd_word[NUM_IRQ-1:0]   = isr_q;
            4'd1:    rd_word[NUM_IRQ-1:0]   = isr_q & ier_q;
            4'd2:    rd_word[NUM_IRQ-1:0]   = ier_q;
            4'd4:    rd_word[LED_WIDTH-1:0] = led_q;
            4'd5:    rd_word                = scratch_q;
            default: rd_word                = '0;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        // Ready is a registered one-cycle pulse; the handshake completes on the cycle it is high.
        case (w_state_q)
            W_IDLE: begin
                if (awready_q) begin
                    awready_d = 1'b0;
                    if (s_axi_awvalid && s_axi_wvalid) begin
                        wr_en     = 1'b1;
                        bvalid_d  = 1'b1;
                        bresp_d   = (wr_idx <= LAST_REG) ? RESP_OKAY : RESP_SLVERR;
                        w_state_d = W_RESP;
                    end
                end else if (s_axi_awvalid && s_axi_wvalid) begin
                    awready_d = 1'b1;
                end
            end
            default: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q) begin
                    arready_d = 1'b0;
                    if (s_axi_arvalid) begin
                        rvalid_d  = 1'b1;
                        rdata_d   = rd_word;
                        rresp_d   = (rd_idx <= LAST_REG) ? RESP_OKAY : RESP_SLVERR;
                        r_state_d = R_DATA;
                    end
                end else if (s_axi_arvalid) begin
                    arready_d = 1'b1;
                end
            end
            default: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ier_d     = ier_q;
        led_d     = led_q;
        scratch_d = scratch_q;
        iar_clr   = '0;
        sw_set    = '0;
        if (wr_en && s_axi_wstrb[0]) begin
            case (wr_idx)
                4'd0: begin
`ifdef AXI_INTC_SW_IRQ_EN
                    sw_set = s_axi_wdata[NUM_IRQ-1:0];
`endif
                end
                4'd2:    ier_d   = s_axi_wdata[NUM_IRQ-1:0];
                4'd3:    iar_clr = s_axi_wdata[NUM_IRQ-1:0];
                4'd4:    led_d   = s_axi_wdata[LED_WIDTH-1:0];
                default: ;
            endcase
        end
        if (wr_en && wr_idx == 4'd5) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) scratch_d[b*8 +: 8] = s_axi_wdata[b*8 +: 8];
            end
        end
        // Set sources are applied after the clear so a coincident set wins.
        isr_d = (isr_q & ~iar_clr) | irq_in | sw_set;
        irq_d = |(isr_q & ier_q);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            isr_q     <= '0;
            ier_q     <= '0;
            led_q     <= '0;
            scratch_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            isr_q     <= isr_d;
            ier_q     <= ier_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            irq_q     <= irq_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign irq           = irq_q;
    assign leds          = led_q;

endmodule
